// File: rtl/dma_pkg.sv
// Shared encodings for the DMA FIFO sequencer: state codes, pointer step and bus direction.
package dma_pkg;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StClear = 3'd1,
    StRead  = 3'd2,
    StWrite = 3'd3,
    StDone  = 3'd4
  } dma_state_e;

  localparam logic [31:0] WordInc  = 32'd4;
  localparam logic        BusRead  = 1'b1;
  localparam logic        BusWrite = 1'b0;

endpackage

// File: rtl/dma_addr_gen.sv
// Loadable 32-bit word pointer stepping by one word; wraps modulo 2^32.
module dma_addr_gen
  import dma_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_load,
  input  logic [31:0] i_load_addr,
  input  logic        i_inc,
  output logic [31:0] o_addr
);

  logic [31:0] r_addr;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_addr <= '0;
    end else if (i_load) begin
      r_addr <= i_load_addr;
    end else if (i_inc) begin
      r_addr <= r_addr + WordInc;
    end
  end

  assign o_addr = r_addr;

endmodule

// File: rtl/dma_fifo_ctrl.sv
// Single-channel DMA sequencer: bursts reads into a staging FIFO, then drains it to the destination.
// Optional completion interrupt enabled by defining DMA_CTRL_IRQ_EN.
module dma_fifo_ctrl
  import dma_pkg::*;
#(
  parameter int unsigned C_DEPTH  = 16,
  parameter int unsigned C_BURST  = 16,
  parameter int unsigned C_LWIDTH = 16
) (
  input  logic                Clk,
  input  logic                Reset_n,
  input  logic                Start,
  input  logic [31:0]         Src_Addr,
  input  logic [31:0]         Dst_Addr,
  input  logic [C_LWIDTH-1:0] Length,
  output logic                Busy,
  output logic                Done,
  output logic                Bus_Req,
  output logic                Bus_RNW,
  output logic [31:0]         Bus_Addr,
  input  logic                Bus_Ack,
  input  logic [31:0]         Bus_RdData,
  output logic [31:0]         Bus_WrData,
  output logic                FIFO_Clear,
  output logic                FIFO_Write,
  output logic [31:0]         FIFO_Data_In,
  output logic                FIFO_Read,
  input  logic [31:0]         FIFO_Data_Out,
  input  logic                FIFO_Full,
`ifdef DMA_CTRL_IRQ_EN
  input  logic                Irq_Clear,
  output logic                Irq,
`endif
  input  logic                FIFO_Empty
);

  localparam int unsigned BW = $clog2(C_BURST + 1);
  localparam int unsigned LW = $clog2(C_DEPTH + 1);

  dma_state_e          r_state, w_state_nxt;
  logic [C_LWIDTH-1:0] r_remain, w_remain_nxt, w_remain_dec;
  logic [BW-1:0]       r_burst, w_burst_nxt, w_burst_inc;
  logic [LW-1:0]       r_level, w_level_nxt, w_level_inc;
  logic                r_wr_arm, w_wr_arm_nxt;
  logic                w_load;
  logic [31:0]         w_src, w_dst;
  logic                w_unused_full;

  // Fill level is tracked here; the FIFO's own full flag lags a cycle behind pushes.
  assign w_unused_full = FIFO_Full;

  dma_addr_gen u_src_gen (
    .i_clk       (Clk),
    .i_rst_n     (Reset_n),
    .i_load      (w_load),
    .i_load_addr (Src_Addr),
    .i_inc       (FIFO_Write),
    .o_addr      (w_src)
  );

  dma_addr_gen u_dst_gen (
    .i_clk       (Clk),
    .i_rst_n     (Reset_n),
    .i_load      (w_load),
    .i_load_addr (Dst_Addr),
    .i_inc       (FIFO_Read),
    .o_addr      (w_dst)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state  <= StIdle;
      r_remain <= '0;
      r_burst  <= '0;
      r_level  <= '0;
      r_wr_arm <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_remain <= w_remain_nxt;
      r_burst  <= w_burst_nxt;
      r_level  <= w_level_nxt;
      r_wr_arm <= w_wr_arm_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_remain_nxt = r_remain;
    w_burst_nxt  = r_burst;
    w_level_nxt  = r_level;
    w_wr_arm_nxt = r_wr_arm;
    w_load       = 1'b0;
    w_remain_dec = r_remain - C_LWIDTH'(1);
    w_burst_inc  = r_burst + BW'(1);
    w_level_inc  = r_level + LW'(1);
    Bus_Req      = 1'b0;
    Bus_RNW      = BusWrite;
    Bus_Addr     = '0;
    Bus_WrData   = '0;
    FIFO_Clear   = 1'b0;
    FIFO_Write   = 1'b0;
    FIFO_Data_In = '0;
    FIFO_Read    = 1'b0;

    case (r_state)
      StIdle: begin
        if (Start) begin
          w_load       = 1'b1;
          w_remain_nxt = Length;
          w_burst_nxt  = '0;
          w_level_nxt  = '0;
          w_state_nxt  = StClear;
        end
      end
      StClear: begin
        FIFO_Clear  = 1'b1;
        w_level_nxt = '0;
        w_burst_nxt = '0;
        w_state_nxt = (r_remain == '0) ? StDone : StRead;
      end
      StRead: begin
        Bus_Req  = 1'b1;
        Bus_RNW  = BusRead;
        Bus_Addr = w_src;
        if (Bus_Ack) begin
          FIFO_Write   = 1'b1;
          FIFO_Data_In = Bus_RdData;
          w_remain_nxt = w_remain_dec;
          w_burst_nxt  = w_burst_inc;
          w_level_nxt  = w_level_inc;
          if ((w_burst_inc == BW'(C_BURST)) || (w_remain_dec == '0) ||
              (w_level_inc == LW'(C_DEPTH))) begin
            w_state_nxt  = StWrite;
            w_wr_arm_nxt = 1'b0;
          end
        end
      end
      StWrite: begin
        // First WRITE cycle is a bus gap so the last push settles in the FIFO.
        w_wr_arm_nxt = 1'b1;
        if (r_wr_arm && (r_level != '0)) begin
          Bus_Req  = 1'b1;
          Bus_RNW  = BusWrite;
          Bus_Addr = w_dst;
          if (Bus_Ack) begin
            FIFO_Read   = 1'b1;
            Bus_WrData  = FIFO_Data_Out;
            w_level_nxt = r_level - LW'(1);
          end
        end else if (r_wr_arm && FIFO_Empty) begin
          w_burst_nxt = '0;
          w_state_nxt = (r_remain != '0) ? StRead : StDone;
        end
      end
      StDone: begin
        w_state_nxt = StIdle;
      end
      default: begin
        w_state_nxt = StIdle;
      end
    endcase
  end

  assign Busy = (r_state == StClear) || (r_state == StRead) || (r_state == StWrite);
  assign Done = (r_state == StDone);

`ifdef DMA_CTRL_IRQ_EN
  logic r_irq;

  // Set has priority over a coincident clear.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_irq <= 1'b0;
    end else if (r_state == StDone) begin
      r_irq <= 1'b1;
    end else if (Irq_Clear) begin
      r_irq <= 1'b0;
    end
  end

  assign Irq = r_irq || (r_state == StDone);
`endif

endmodule

// File: tb/tb_dma_fifo_ctrl.sv
// Scoreboard bench for dma_fifo_ctrl with behavioural bus slave and staging FIFO models.
// Covers DMA_CTRL_IRQ_EN behaviour when that macro is defined.
module tb_dma_fifo_ctrl;

  localparam int unsigned Depth  = 16;
  localparam int unsigned Burst  = 16;
  localparam int unsigned LWidth = 16;

  logic              Clk, Reset_n, Start;
  logic [31:0]       Src_Addr, Dst_Addr;
  logic [LWidth-1:0] Length;
  logic              Busy, Done, Bus_Req, Bus_RNW, Bus_Ack;
  logic [31:0]       Bus_Addr, Bus_RdData, Bus_WrData;
  logic              FIFO_Clear, FIFO_Write, FIFO_Read, FIFO_Full, FIFO_Empty;
  logic [31:0]       FIFO_Data_In, FIFO_Data_Out;
`ifdef DMA_CTRL_IRQ_EN
  logic              Irq_Clear, Irq;
`endif

  dma_fifo_ctrl #(
    .C_DEPTH  (Depth),
    .C_BURST  (Burst),
    .C_LWIDTH (LWidth)
  ) dut (
    .Clk           (Clk),
    .Reset_n       (Reset_n),
    .Start         (Start),
    .Src_Addr      (Src_Addr),
    .Dst_Addr      (Dst_Addr),
    .Length        (Length),
    .Busy          (Busy),
    .Done          (Done),
    .Bus_Req       (Bus_Req),
    .Bus_RNW       (Bus_RNW),
    .Bus_Addr      (Bus_Addr),
    .Bus_Ack       (Bus_Ack),
    .Bus_RdData    (Bus_RdData),
    .Bus_WrData    (Bus_WrData),
    .FIFO_Clear    (FIFO_Clear),
    .FIFO_Write    (FIFO_Write),
    .FIFO_Data_In  (FIFO_Data_In),
    .FIFO_Read     (FIFO_Read),
    .FIFO_Data_Out (FIFO_Data_Out),
    .FIFO_Full     (FIFO_Full),
`ifdef DMA_CTRL_IRQ_EN
    .Irq_Clear     (Irq_Clear),
    .Irq           (Irq),
`endif
    .FIFO_Empty    (FIFO_Empty)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // kind: 0 = read ack, 1 = write ack, 2 = Done pulse
  typedef struct {
    int          kind;
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   ack_dly = 0;
  int   n_rd_ack = 0;

  function automatic logic [31:0] rd_pat(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h0F0F_0000;
  endfunction

  function automatic logic [31:0] outs_or();
    logic [31:0] v;
    v = {22'd0, Busy, Done, Bus_Req, Bus_RNW, FIFO_Clear, FIFO_Write, FIFO_Read,
         |Bus_Addr, |Bus_WrData, |FIFO_Data_In};
`ifdef DMA_CTRL_IRQ_EN
    v[31] = Irq;
`endif
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: got 1, required 0", name);
  endtask

  // Bus slave: acks after ack_dly waiting cycles of a held request.
  initial begin
    int wcnt;
    wcnt = 0;
    Bus_Ack = 1'b0;
    Bus_RdData = '0;
    forever begin
      @(posedge Clk);
      #2;
      if (Bus_Req && (wcnt >= ack_dly)) begin
        Bus_Ack    = 1'b1;
        Bus_RdData = Bus_RNW ? rd_pat(Bus_Addr) : 32'd0;
        wcnt       = 0;
      end else begin
        Bus_Ack    = 1'b0;
        Bus_RdData = '0;
        wcnt       = Bus_Req ? wcnt + 1 : 0;
      end
    end
  end

  // Staging FIFO model with registered flags and combinational head.
  initial begin
    logic [31:0] fq[$];
    logic        s_clr, s_wr, s_rd;
    logic [31:0] s_din;
    FIFO_Empty    = 1'b1;
    FIFO_Full     = 1'b0;
    FIFO_Data_Out = '0;
    forever begin
      @(negedge Clk);
      s_clr = FIFO_Clear;
      s_wr  = FIFO_Write;
      s_rd  = FIFO_Read;
      s_din = FIFO_Data_In;
      @(posedge Clk);
      #1;
      if (s_clr) begin
        fq.delete();
      end else begin
        if (s_rd) begin
          if (fq.size() == 0) fail_now("fifo_underflow");
          else void'(fq.pop_front());
        end
        if (s_wr) begin
          if (fq.size() >= Depth) fail_now("fifo_overflow");
          else fq.push_back(s_din);
        end
      end
      FIFO_Empty    = (fq.size() == 0);
      FIFO_Full     = (fq.size() >= Depth);
      FIFO_Data_Out = (fq.size() != 0) ? fq[0] : 32'd0;
    end
  end

  // Monitor: pops the scoreboard on every accepted bus transfer and Done pulse.
  logic        prev_req = 1'b0;
  logic        prev_ack = 1'b0;
  logic        exp_gap  = 1'b0;
  logic [31:0] prev_addr = '0;
  exp_t        me;

  always @(negedge Clk) begin
    if (!Reset_n) begin
      prev_req = 1'b0;
      prev_ack = 1'b0;
      exp_gap  = 1'b0;
    end else begin
      if (exp_gap) begin
        chk("req_gap_after_burst", {31'd0, Bus_Req}, 32'd0);
        exp_gap = 1'b0;
      end
      if (prev_req && !prev_ack && Bus_Req) chk("addr_hold", Bus_Addr, prev_addr);
      if (FIFO_Write && FIFO_Read) fail_now("fifo_wr_rd_same_cycle");
      if ((FIFO_Write || FIFO_Read) && !(Bus_Req && Bus_Ack)) fail_now("fifo_op_without_ack");
      if (Bus_Req && Bus_Ack) begin
        if (exp_q.size() == 0) begin
          fail_now("unexpected_bus_ack");
        end else begin
          me = exp_q.pop_front();
          chk("bus_dir", Bus_RNW ? 32'd0 : 32'd1, 32'(me.kind));
          chk("bus_addr", Bus_Addr, me.addr);
          if (Bus_RNW) begin
            n_rd_ack++;
            chk("fifo_write", {31'd0, FIFO_Write}, 32'd1);
            chk("fifo_din", FIFO_Data_In, me.data);
            if (exp_q.size() == 0 || exp_q[0].kind != 0) exp_gap = 1'b1;
          end else begin
            chk("fifo_read", {31'd0, FIFO_Read}, 32'd1);
            chk("wr_data", Bus_WrData, me.data);
          end
        end
      end else if (Bus_WrData != 32'd0) begin
        fail_now("wr_data_idle_nonzero");
      end
      if (Done) begin
        if (exp_q.size() == 0) begin
          fail_now("unexpected_done");
        end else begin
          me = exp_q.pop_front();
          chk("done_order", 32'(me.kind), 32'd2);
          chk("done_busy", {31'd0, Busy}, 32'd0);
        end
      end
      prev_req  = Bus_Req;
      prev_ack  = Bus_Ack;
      prev_addr = Bus_Addr;
    end
  end

  task automatic push_xfer(input logic [31:0] src, input logic [31:0] dst, input int len);
    exp_t        e;
    int          rem;
    int          n;
    logic [31:0] s, d;
    rem = len;
    s   = src;
    d   = dst;
    while (rem > 0) begin
      n = rem;
      if (n > int'(Burst)) n = Burst;
      if (n > int'(Depth)) n = Depth;
      for (int i = 0; i < n; i++) begin
        e.kind = 0;
        e.addr = s + 32'(4 * i);
        e.data = rd_pat(e.addr);
        exp_q.push_back(e);
      end
      for (int i = 0; i < n; i++) begin
        e.kind = 1;
        e.addr = d + 32'(4 * i);
        e.data = rd_pat(s + 32'(4 * i));
        exp_q.push_back(e);
      end
      s   = s + 32'(4 * n);
      d   = d + 32'(4 * n);
      rem = rem - n;
    end
    e.kind = 2;
    e.addr = '0;
    e.data = '0;
    exp_q.push_back(e);
  endtask

  // Start held a second cycle with junk operands: that second sample must be ignored.
  task automatic start_xfer(input logic [31:0] src, input logic [31:0] dst, input int len);
    @(posedge Clk);
    #1;
    Src_Addr = src;
    Dst_Addr = dst;
    Length   = LWidth'(len);
    Start    = 1'b1;
    @(posedge Clk);
    #1;
    Src_Addr = 32'hDEAD_BEE0;
    Dst_Addr = 32'hCAFE_0000;
    Length   = 16'd7;
    chk("start_busy", {31'd0, Busy}, 32'd1);
    chk("start_clear", {31'd0, FIFO_Clear}, 32'd1);
    @(posedge Clk);
    #1;
    Start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) @(posedge Clk);
    if (exp_q.size() != 0) begin
      fail_now("transfer_timeout");
      exp_q.delete();
    end
    @(posedge Clk);
    #1;
    chk("idle_busy", {31'd0, Busy}, 32'd0);
    chk("idle_done", {31'd0, Done}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset_n  = 1'b0;
    Start    = 1'b0;
    Src_Addr = '0;
    Dst_Addr = '0;
    Length   = '0;
`ifdef DMA_CTRL_IRQ_EN
    Irq_Clear = 1'b0;
`endif
    repeat (3) @(posedge Clk);
    #1;
    chk("reset_outputs", outs_or(), 32'd0);
    Reset_n = 1'b1;

    ack_dly = 0;
    push_xfer(32'h100, 32'h200, 5);
    start_xfer(32'h100, 32'h200, 5);
    wait_done(500);
`ifdef DMA_CTRL_IRQ_EN
    chk("irq_hold", {31'd0, Irq}, 32'd1);
    Irq_Clear = 1'b1;
    @(posedge Clk);
    #1;
    Irq_Clear = 1'b0;
    chk("irq_cleared", {31'd0, Irq}, 32'd0);
`endif

    push_xfer(32'h1000, 32'h8000, 40);
    start_xfer(32'h1000, 32'h8000, 40);
    wait_done(1000);

    // Zero length: CLEAR then DONE, no bus traffic.
    push_xfer(32'h40, 32'h80, 0);
    @(posedge Clk);
    #1;
    Src_Addr = 32'h40;
    Dst_Addr = 32'h80;
    Length   = '0;
    Start    = 1'b1;
    @(posedge Clk);
    #1;
    Start = 1'b0;
    chk("len0_clear", {31'd0, FIFO_Clear}, 32'd1);
`ifdef DMA_CTRL_IRQ_EN
    Irq_Clear = 1'b1;
`endif
    @(posedge Clk);
    #1;
    chk("len0_done", {31'd0, Done}, 32'd1);
    chk("len0_no_req", {31'd0, Bus_Req}, 32'd0);
`ifdef DMA_CTRL_IRQ_EN
    chk("irq_with_done", {31'd0, Irq}, 32'd1);
`endif
    @(posedge Clk);
    #1;
`ifdef DMA_CTRL_IRQ_EN
    Irq_Clear = 1'b0;
    chk("irq_set_wins", {31'd0, Irq}, 32'd1);
`endif
    chk("len0_done_once", {31'd0, Done}, 32'd0);
    chk("len0_sb_empty", 32'(exp_q.size()), 32'd0);

    ack_dly = 3;
    push_xfer(32'h300, 32'h400, 4);
    start_xfer(32'h300, 32'h400, 4);
    wait_done(500);
    ack_dly = 0;

    push_xfer(32'hFFFF_FFF8, 32'hFFFF_FFFC, 3);
    start_xfer(32'hFFFF_FFF8, 32'hFFFF_FFFC, 3);
    wait_done(200);

    // Reset in the middle of the read burst, then a fresh short transfer.
    n_rd_ack = 0;
    push_xfer(32'h500, 32'h600, 5);
    start_xfer(32'h500, 32'h600, 5);
    for (int i = 0; i < 100 && n_rd_ack < 3; i++) @(posedge Clk);
    if (n_rd_ack < 3) fail_now("reset_wait_timeout");
    #3;
    Reset_n = 1'b0;
    #1;
    chk("mid_reset_outputs", outs_or(), 32'd0);
    exp_q.delete();
    @(posedge Clk);
    #1;
    Reset_n = 1'b1;
    push_xfer(32'h700, 32'h800, 2);
    start_xfer(32'h700, 32'h800, 2);
    wait_done(200);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
